// File: rtl/ysyx_2022040010_regfile.sv
// Integer register file for the pipeline write-back stage.
// It holds 32 x 64-bit GPRs with x0 hard-wired to zero.
// There are two combinational ID read ports with same-cycle write bypass,
// one synchronous write port, an unbypassed debug read port for difftest,
// and the retired-instruction counter.
module ysyx_2022040010_regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int BUS_W  = 1 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  wb_to_rf_bus,
    input  logic              wb_bubble,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [63:0]       instret
);

    localparam int NPORT = 2;

    // Unpack the write-back bus. This is a pure slice, MSB first.
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    assign {rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus;

    // Writes to x0 are dropped here, so entry 0 stays zero.
    // Reads still force x0 to zero explicitly.
    logic wr_en;
    assign wr_en = rf_we && (rf_waddr != '0);

    logic [DATA_W-1:0] regs_reg [NREG];
    logic [63:0]       instret_reg;

    // Architectural register state: async clear, synchronous single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[rf_waddr] <= rf_wdata;
        end
    end

    // Retired-instruction counter. It counts every non-bubble WB slot,
    // whether or not that slot writes a register. It wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_reg <= '0;
        end else if (!wb_bubble) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign instret = instret_reg;

    // Both ID read ports share identical logic.
    // They are gathered into arrays so one generate loop builds them.
    logic [ADDR_W-1:0] raddr_arr [NPORT];
    logic [DATA_W-1:0] rdata_arr [NPORT];

    assign raddr_arr[0] = raddr1;
    assign raddr_arr[1] = raddr2;
    assign rdata1       = rdata_arr[0];
    assign rdata2       = rdata_arr[1];

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_rport
            // Read port priority: reset or x0 gives zero, then bypass, then stored value.
            always_comb begin
                rdata_arr[gi] = '0;
                if (rst || raddr_arr[gi] == '0) begin
                    rdata_arr[gi] = '0;
                end else if (wr_en && rf_waddr == raddr_arr[gi]) begin
                    rdata_arr[gi] = rf_wdata;
                end else begin
                    rdata_arr[gi] = regs_reg[raddr_arr[gi]];
                end
            end
        end
    endgenerate

    // The debug port shows only committed state, so it never bypasses.
    always_comb begin
        dbg_rdata = '0;
        if (!rst && dbg_raddr != '0) begin
            dbg_rdata = regs_reg[dbg_raddr];
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_regfile.sv
// Self-checking bench for ysyx_2022040010_regfile.
// It uses directed scenarios followed by a random phase,
// checked against an array-based model of the register file.
module tb_ysyx_2022040010_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [69:0] wb_to_rf_bus;
    logic        wb_bubble;
    logic [4:0]  raddr1, raddr2, dbg_raddr;
    logic [63:0] rdata1, rdata2, dbg_rdata, instret;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [63:0] model [32];
    logic [63:0] instret_m;

    ysyx_2022040010_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wb_to_rf_bus),
        .wb_bubble    (wb_bubble),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value the ID port must show: x0 is zero, a live write is forwarded,
    // and otherwise the committed value is returned.
    function automatic logic [63:0] ref_read(input logic we, input logic [4:0] wa,
                                             input logic [63:0] wd, input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (we && wa == a) return wd;
        return model[a];
    endfunction

    function automatic logic [63:0] ref_dbg(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : model[a];
    endfunction

    // One clock of traffic. Inputs are applied on the falling edge,
    // outputs are checked just before the rising edge,
    // and then the model commits.
    task automatic step(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic bub, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input string tag);
        @(negedge clk);
        wb_to_rf_bus = {we, wa, wd};
        wb_bubble    = bub;
        raddr1       = r1;
        raddr2       = r2;
        dbg_raddr    = d;
        #1;
        chk({tag, ".rdata1"},  rdata1,    ref_read(we, wa, wd, r1));
        chk({tag, ".rdata2"},  rdata2,    ref_read(we, wa, wd, r2));
        chk({tag, ".dbg"},     dbg_rdata, ref_dbg(d));
        chk({tag, ".instret"}, instret,   instret_m);
        $display("step %s we=%0b wa=%0d wd=%h bub=%0b r1=%0d r2=%0d d=%0d rd1=%h rd2=%h dbg=%h ir=%0d",
                 tag, we, wa, wd, bub, r1, r2, d, rdata1, rdata2, dbg_rdata, instret);
        @(posedge clk);
        if (we && wa != 5'd0) model[wa] = wd;
        if (!bub) instret_m = instret_m + 64'd1;
    endtask

    // Assert reset mid-cycle with a write still on the bus.
    // Everything must read zero at once, without any clock edge.
    task automatic mid_reset(input logic [4:0] a);
        @(negedge clk);
        wb_to_rf_bus = {1'b1, a, 64'hABCD_0000_1111_2222};
        wb_bubble    = 1'b0;
        raddr1       = a;
        raddr2       = a;
        dbg_raddr    = a;
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        instret_m = 64'd0;
        chk("rst.rdata1",  rdata1,    64'd0);
        chk("rst.rdata2",  rdata2,    64'd0);
        chk("rst.dbg",     dbg_rdata, 64'd0);
        chk("rst.instret", instret,   64'd0);
        $display("reset asserted mid-cycle addr=%0d rd1=%h dbg=%h ir=%0d", a, rdata1, dbg_rdata, instret);
        // The write presented on this edge must be lost.
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb_to_rf_bus = '0;
        wb_bubble    = 1'b1;
        #1;
        chk("rst.lost_write", dbg_rdata, 64'd0);
        chk("rst.no_count",   instret,   64'd0);
    endtask

    initial begin
        rst = 1'b1;
        wb_to_rf_bus = '0;
        wb_bubble = 1'b1;
        raddr1 = '0;
        raddr2 = '0;
        dbg_raddr = '0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        instret_m = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.instret", instret, 64'd0);

        // Scenario 1: write x5, then reset asynchronously.
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd5, 5'd0, 5'd5, "t1.wr");
        step(1'b0, 5'd0, 64'd0,    1'b1, 5'd5, 5'd5, 5'd5, "t1.rd");
        mid_reset(5'd5);

        // Scenario 2: bypass onto x10. The debug port shows the old value first.
        step(1'b1, 5'd10, 64'h1111, 1'b1, 5'd0, 5'd0, 5'd0, "t2.pre");
        step(1'b1, 5'd10, 64'hDEAD_BEEF, 1'b0, 5'd10, 5'd10, 5'd10, "t2.byp");
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 5'd0, 5'd10, "t2.after");

        // Scenario 3: writes to x0 are discarded.
        step(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0, "t3.wr0");
        step(1'b0, 5'd0, 64'd0,    1'b1, 5'd0, 5'd0, 5'd0, "t3.rd0");

        // Scenario 5: rf_we=0 gives no write and no bypass.
        step(1'b0, 5'd3, 64'h55, 1'b0, 5'd3, 5'd3, 5'd3, "t5.nowe");
        step(1'b0, 5'd0, 64'd0,  1'b1, 5'd3, 5'd3, 5'd3, "t5.chk");

        // Scenario 4: 7 retires interleaved with 3 bubbles, counted from a fresh reset.
        mid_reset(5'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, 64'd0, (i % 3 == 1) ? 1'b1 : 1'b0, 5'd0, 5'd0, 5'd0, "t4.cnt");
        end
        @(negedge clk);
        wb_bubble = 1'b1;
        #1;
        chk("t4.instret7", instret, 64'd7);
        // Preload the counter with all ones, then retire once: it must wrap to 0.
        force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_reg;
        instret_m = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, "t4.max");
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0, "t4.wrap");
        chk("t4.wrap_zero", instret, 64'd0);

        // Scenario 6: fill x1..x31, then read every register on all three ports.
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'(i), 64'(i) * 64'h1111, 1'($urandom_range(0, 1)),
                 5'(i), 5'($urandom_range(0, 31)), 5'(i), "t6.wr");
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'(i), 64'hBAD, 1'b1, 5'(i), 5'(31 - i), 5'(i), "t6.rd");
            chk("t6.expect", dbg_rdata, 64'(i) * 64'h1111);
        end

        // Random traffic checked against the model.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
